// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen: 4-channel frame-synchronous ESC pulse generator with clamped per-channel commands.
// Define MOTOR_PWM_WATCHDOG_EN to add the command-loss failsafe watchdog (TIMEOUT_FRAMES).
module motor_pwm_gen #(
   parameter int unsigned CLK_HZ         = 100000000,
   parameter int unsigned PWM_HZ         = 400,
   parameter int unsigned MIN_US         = 1000,
   parameter int unsigned MAX_US         = 2000,
   parameter int unsigned TIMEOUT_FRAMES = 40
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_ch,
   input  logic [11:0] cmd_pulse_us,
   input  logic        arm,
   output logic [3:0]  motor_out,
   output logic        armed,
   output logic        failsafe,
   output logic        frame_start
);

   localparam int unsigned DIV       = CLK_HZ / 1000000;
   localparam int unsigned PERIOD_US = 1000000 / PWM_HZ;
   localparam int unsigned PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
   localparam logic [11:0] PCNT_MAX  = 12'(PERIOD_US - 1);
   localparam logic [11:0] MIN_W     = 12'(MIN_US);
   localparam logic [11:0] MAX_W     = 12'(MAX_US);

   if (CLK_HZ % 1000000 != 0 || DIV == 0 || PERIOD_US > 4095 || MIN_US >= MAX_US ||
       MAX_US >= PERIOD_US || TIMEOUT_FRAMES < 2) begin : g_bad_cfg
      $error("motor_pwm_gen: invalid parameter set");
   end

   // State bits double as the armed/failsafe outputs.
   typedef enum logic [1:0] {
      DISARMED = 2'b00,
      ARMED    = 2'b01,
      FAILSAFE = 2'b11
   } state_t;

   state_t        state;
   logic [PW-1:0] pre;
   logic [11:0]   pcnt;
   logic [11:0]   shadow [4];
   logic [11:0]   active [4];
   logic [11:0]   clamped;
   logic          tick, boundary, accept, trip;

   always_comb begin
      tick     = (pre == PRE_MAX);
      boundary = tick && (pcnt == PCNT_MAX);
      accept   = cmd_valid && cmd_ready;
      clamped  = cmd_pulse_us;
      if (cmd_pulse_us < MIN_W)
         clamped = MIN_W;
      else if (cmd_pulse_us > MAX_W)
         clamped = MAX_W;
   end

`ifdef MOTOR_PWM_WATCHDOG_EN
   localparam int unsigned WW = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [WW-1:0] W_MAX = WW'(TIMEOUT_FRAMES);
   logic [WW-1:0] wcnt;

   // Trip decision uses the count before this boundary plus the boundary itself.
   assign trip = (32'(wcnt) + 32'd1 >= TIMEOUT_FRAMES);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         wcnt <= '0;
      else if ((boundary && !arm) || accept)
         wcnt <= '0;
      else if (boundary && wcnt != W_MAX)
         wcnt <= wcnt + WW'(1);
   end
`else
   assign trip = 1'b0;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= DISARMED;
         pre         <= '0;
         pcnt        <= '0;
         cmd_ready   <= 1'b0;
         frame_start <= 1'b0;
         motor_out   <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            shadow[i] <= MIN_W;
            active[i] <= MIN_W;
         end
      end else begin
         cmd_ready   <= 1'b1;
         frame_start <= boundary;
         pre         <= tick ? '0 : pre + PW'(1);
         if (tick)
            pcnt <= boundary ? '0 : pcnt + 12'd1;
         for (int unsigned i = 0; i < 4; i++)
            motor_out[i] <= (pcnt < active[i]);
         if (accept)
            shadow[cmd_ch] <= clamped;
         // Active loads pre-edge shadow; disarm also overrides a same-cycle accept.
         if (boundary) begin
            if (!arm) begin
               state <= DISARMED;
               for (int unsigned i = 0; i < 4; i++) begin
                  shadow[i] <= MIN_W;
                  active[i] <= MIN_W;
               end
            end else if (trip) begin
               state <= FAILSAFE;
               for (int unsigned i = 0; i < 4; i++)
                  active[i] <= MIN_W;
            end else begin
               state <= ARMED;
               for (int unsigned i = 0; i < 4; i++)
                  active[i] <= shadow[i];
            end
         end
      end
   end

   assign armed    = state[0];
   assign failsafe = state[1];

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Self-checking bench for motor_pwm_gen: directed steps plus random commands against a frame-level model.
module tb_motor_pwm_gen;

   localparam int DIV = 3;
   localparam int P   = 80;
   localparam int F   = DIV * P;
   localparam int MIN = 20;
   localparam int MAX = 50;
   localparam int T   = 4;
`ifdef MOTOR_PWM_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_ch = '0;
   logic [11:0] cmd_pulse_us = '0;
   logic        arm = 1'b0;
   logic        cmd_ready, armed, failsafe, frame_start;
   logic [3:0]  motor_out;

   int checks = 0;
   int errors = 0;

   motor_pwm_gen #(
      .CLK_HZ(3000000), .PWM_HZ(12500), .MIN_US(MIN), .MAX_US(MAX), .TIMEOUT_FRAMES(T)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_pulse_us(cmd_pulse_us), .arm(arm), .motor_out(motor_out),
      .armed(armed), .failsafe(failsafe), .frame_start(frame_start)
   );

   always #5 aclk = ~aclk;

   // Reference model: edge n after reset release; frames are F edges long.
   int n = 0;
   int fcnt;
   int shadow_m [4];
   int cur_w [4];
   bit fs_m, armed_m, exp_fs;
   bit exp_valid = 1'b0;
   logic [3:0] exp_out;
   int pc;

   function automatic int clampf(int v);
      return (v < MIN) ? MIN : ((v > MAX) ? MAX : v);
   endfunction

   always @(posedge aclk) begin
      if (!aresetn) begin
         n = 0; fcnt = 0; fs_m = 0; armed_m = 0; exp_valid = 0;
         for (int i = 0; i < 4; i++) begin shadow_m[i] = MIN; cur_w[i] = MIN; end
      end else begin
         n++;
         pc = ((n - 1) / DIV) % P;
         for (int i = 0; i < 4; i++) exp_out[i] = (pc < cur_w[i]);
         exp_fs = (n % F == 0);
         if (exp_fs) begin
            if (!arm) fcnt = 0;
            else if (fcnt < T) fcnt++;
            fs_m = WD && arm && (fcnt >= T);
            armed_m = arm;
            for (int i = 0; i < 4; i++) cur_w[i] = (arm && !fs_m) ? shadow_m[i] : MIN;
         end
         if (cmd_valid && n > 1) begin
            shadow_m[cmd_ch] = clampf(int'(cmd_pulse_us));
            fcnt = 0;
         end
         if (exp_fs && !arm)
            for (int i = 0; i < 4; i++) shadow_m[i] = MIN;
         exp_valid = 1'b1;
      end
   end

   int mism [4];
   int hi [4];
   int ehi [4];
   int fmis;

   always @(negedge aclk) begin
      if (!aresetn || !exp_valid) begin
         fmis = 0;
         for (int i = 0; i < 4; i++) begin mism[i] = 0; hi[i] = 0; ehi[i] = 0; end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (motor_out[i] !== exp_out[i]) mism[i]++;
            if (motor_out[i] === 1'b1) hi[i]++;
            if (exp_out[i]) ehi[i]++;
         end
         if (frame_start !== exp_fs) fmis++;
         if (exp_fs) begin
            checks++;
            assert (armed === armed_m) else begin
               errors++; $error("FAIL armed n=%0d observed %b expected %b", n, armed, armed_m);
            end
            checks++;
            assert (failsafe === fs_m) else begin
               errors++; $error("FAIL failsafe n=%0d observed %b expected %b", n, failsafe, fs_m);
            end
            for (int i = 0; i < 4; i++) begin
               checks++;
               assert (mism[i] === 0) else begin
                  errors++;
                  $error("FAIL frame_wave ch%0d n=%0d observed high=%0d (bad cycles %0d) expected high=%0d",
                         i, n, hi[i], mism[i], ehi[i]);
               end
               mism[i] = 0; hi[i] = 0; ehi[i] = 0;
            end
            checks++;
            assert (fmis === 0) else begin
               errors++; $error("FAIL frame_start n=%0d observed %0d bad cycles expected 0", n, fmis);
            end
            fmis = 0;
         end
      end
   end

   task automatic tick_n(int k);
      repeat (k) @(negedge aclk);
   endtask

   task automatic next_frame();
      int k;
      k = 0;
      do begin
         @(negedge aclk);
         k++;
      end while (!(n % F == 0 && n > 0) && k <= F + 1);
      if (k > F + 1) begin
         checks++; errors++;
         $error("FAIL frame_wait observed no boundary in %0d cycles expected one within %0d", k, F);
      end
   endtask

   task automatic send(int ch, int v);
      @(negedge aclk);
      checks++;
      assert (cmd_ready === 1'b1) else begin
         errors++; $error("FAIL cmd_ready observed %b expected 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_ch = 2'(ch); cmd_pulse_us = 12'(v);
      @(negedge aclk);
      cmd_valid = 1'b0;
   endtask

   task automatic measure(int w0, int w1, int w2, int w3, string tag);
      int c [4];
      int w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < 4; i++) c[i] = 0;
      if (n % F != 0) next_frame();
      repeat (F) begin
         @(negedge aclk);
         for (int i = 0; i < 4; i++) if (motor_out[i] === 1'b1) c[i]++;
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         assert (c[i] === w[i] * DIV) else begin
            errors++; $error("FAIL %s ch%0d observed %0d cycles expected %0d", tag, i, c[i], w[i] * DIV);
         end
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL global_timeout observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int k, r, sel, v;
      tick_n(3);
      checks++; assert (motor_out === 4'h0) else begin errors++; $error("FAIL rst_motor observed %h expected 0", motor_out); end
      checks++; assert (cmd_ready === 1'b0) else begin errors++; $error("FAIL rst_ready observed %b expected 0", cmd_ready); end
      checks++; assert ({armed, failsafe, frame_start} === 3'b000) else begin
         errors++; $error("FAIL rst_flags observed %b expected 000", {armed, failsafe, frame_start});
      end
      #2 aresetn = 1'b1;
      @(negedge aclk);
      checks++; assert (cmd_ready === 1'b1) else begin errors++; $error("FAIL ready_after_rst observed %b expected 1", cmd_ready); end
      checks++; assert (motor_out === 4'hF) else begin errors++; $error("FAIL first_rise observed %h expected f", motor_out); end

      measure(MIN, MIN, MIN, MIN, "disarmed_idle");

      arm = 1'b1;
      send(2, 35);
      next_frame();
      checks++; assert (armed === 1'b1) else begin errors++; $error("FAIL armed_on observed %b expected 1", armed); end
      measure(MIN, MIN, 35, MIN, "ch2_cmd");

      send(0, 0); send(1, 4095); send(3, MAX);
      next_frame();
      measure(MIN, MAX, 35, MAX, "clamp");

      k = 0;
      while (n % F != F - 1 && k <= F) begin @(negedge aclk); k++; end
      cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_pulse_us = 12'd45;
      @(negedge aclk);
      cmd_valid = 1'b0;
      measure(MIN, MAX, 35, MAX, "edge_accept_old");
      measure(MIN, 45, 35, MAX, "edge_accept_new");

      arm = 1'b0;
      next_frame();
      measure(MIN, MIN, MIN, MIN, "disarm");
      arm = 1'b1;
      next_frame();
      measure(MIN, MIN, MIN, MIN, "rearm_no_replay");

      for (int it = 0; it < 40; it++) begin
         tick_n($urandom_range(1, 250));
         r = $urandom_range(0, 7);
         if (r == 0) arm = ~arm;
         else begin
            sel = $urandom_range(0, 3);
            if (sel == 0) v = $urandom_range(0, MIN);
            else if (sel == 1) v = $urandom_range(MAX, 4095);
            else v = $urandom_range(MIN, MAX);
            send($urandom_range(0, 3), v);
         end
      end
      arm = 1'b1;
      next_frame(); next_frame();

      arm = 1'b0;
      next_frame();
      arm = 1'b1;
      send(0, 40);
      repeat (T) next_frame();
      checks++; assert (failsafe === WD) else begin errors++; $error("FAIL wd_trip observed %b expected %b", failsafe, WD); end
      measure(WD ? MIN : 40, MIN, MIN, MIN, "wd_frame");
      send(0, 40);
      next_frame();
      checks++; assert (failsafe === 1'b0) else begin errors++; $error("FAIL wd_clear observed %b expected 0", failsafe); end
      measure(40, MIN, MIN, MIN, "wd_restore");

      send(3, MAX);
      next_frame();
      measure(40, MIN, MIN, MAX, "pre_reset");
      tick_n(5);
      checks++; assert (motor_out === 4'hF) else begin errors++; $error("FAIL mid_pulse observed %h expected f", motor_out); end
      #2 aresetn = 1'b0;
      #1;
      checks++; assert (motor_out === 4'h0) else begin errors++; $error("FAIL async_rst_motor observed %h expected 0", motor_out); end
      checks++; assert ({cmd_ready, armed} === 2'b00) else begin
         errors++; $error("FAIL async_rst_flags observed %b expected 00", {cmd_ready, armed});
      end
      tick_n(3);
      #2 aresetn = 1'b1;
      next_frame();
      measure(MIN, MIN, MIN, MIN, "shadow_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
